stg_ma_mp: RTL and testbench
============================

Name: stg_ma_mp

Overview:
Parametrised memory-address pipeline stage sitting between EX and MO.
- Carries the instruction bundle forward under a valid/ready handshake and absorbs one cycle of downstream stall with a skid entry.
- Presents each accepted memory address on one of NUM_PORTS registered memory-address ports, selected by a rotating port pointer. The port index travels with the bundle so MO accesses exactly the port MA loaded.
- Replaces the fixed two-port, always-advancing MA register stage.

Parameters:
- ADDR_W, 24, address width.
- PAY_W, 96, opaque sideband payload width (pc, instr, opc, targets, write-enables, results, CR controls packed upstream).
- NUM_PORTS, 2, number of memory-address ports; must be >= 2.
- PTR_MODE, 0, 0 = pointer advances every cycle (legacy free-running), 1 = pointer advances only on an accepted memory transfer.

Ports:
- iw_clk  in  1  clock.
- iw_rst_n  in  1  asynchronous active-low reset.
- iw_valid  in  1  upstream bundle valid.
- ow_ready  out  1  stage can accept (skid entry empty).
- iw_mem_req  in  1  bundle performs a memory access.
- iw_wide  in  1  access is 48-bit (two address units).
- iw_addr  in  ADDR_W  memory address.
- iw_payload  in  PAY_W  sideband bundle.
- iw_flush  in  1  discard all held bundles.
- ow_valid  out  1  output bundle valid.
- iw_ready  in  1  MO accepts output.
- ow_payload  out  PAY_W  registered sideband.
- ow_mem_req  out  1  registered iw_mem_req.
- ow_wide  out  1  registered iw_wide.
- ow_mem_port  out  $clog2(NUM_PORTS)  port MO must use for this bundle.
- ow_mem_addr  out  NUM_PORTS*ADDR_W  flat registered per-port addresses; port k is bits [k*ADDR_W +: ADDR_W].
- ow_fault  out  1  misalignment fault (optional feature only; otherwise tied 0).

Behaviour:
- Reset (iw_rst_n low, asynchronous):
  - ow_valid = 0, ow_ready = 1, ow_payload = 0, ow_mem_req = 0, ow_wide = 0, ow_mem_port = 0, all ow_mem_addr = 0, ow_fault = 0.
  - Pointer r_ptr = 0. Skid entry empty.
  - Reset mid-transfer drops every in-flight bundle; no partial state survives.
- Storage:
  - Output register O plus skid register S. Each holds payload, mem_req, wide, port and addr.
  - ow_ready = !S.valid, registered.
- Accept:
  - Occurs when iw_valid && ow_ready.
  - If O is empty, or O is being drained (iw_ready) with S empty, the bundle loads O. Latency is 1 cycle.
  - Otherwise the bundle loads S.
- Drain:
  - On ow_valid && iw_ready, O is reloaded from S if S is valid, else from the input if accepting, else O becomes invalid.
  - Ordering is strictly FIFO.
- Port allocation:
  - An accepted bundle with iw_mem_req = 1 is assigned port p = r_ptr.
  - iw_addr is written into port register p on the accept cycle. The address is therefore visible to MO one cycle later and held until that port is next allocated.
  - Unallocated ports hold their value; there are no latches.
  - Bundles with iw_mem_req = 0 carry port 0 and write no port register.
- Pointer update:
  - Increments modulo NUM_PORTS, wrapping NUM_PORTS-1 -> 0.
  - PTR_MODE=0: increments every cycle out of reset.
  - PTR_MODE=1: increments only on an accepted iw_mem_req bundle.
- Port conflict (PTR_MODE=1):
  - A port must not be reallocated while a held bundle still references it.
  - If the next port equals S.port or O.port of a valid memory bundle, ow_ready is deasserted for that cycle.
- Flush:
  - iw_flush clears O.valid, S.valid and ow_fault the next edge; the pointer is untouched.
  - Flush wins over a simultaneous accept, which is discarded.
- Simultaneous accept and drain with S empty is a pass-through into O.

Optional Feature:
- Macro STG_MA_ALIGN_CHK_EN.
- Defined: an accepted bundle with iw_mem_req && iw_wide && iw_addr[0] = 1 sets ow_fault alongside the bundle in O, and ow_mem_req for it is forced 0, so no port is written and the pointer does not advance in PTR_MODE=1. The fault clears when that bundle drains or on flush.
- Undefined: ow_fault is constant 0 and no alignment check exists.

Decomposition:
- Shared package/header gets:
  - PTR_W = $clog2(NUM_PORTS) helper.
  - Bundle field offsets for PAY_W packing (pc, instr, opc, tgt_gp/sr/ar, results, CR fields).
  - PTR_MODE encodings.
- One sub-module, stg_ma_skid: the generic two-entry O/S skid register with valid/ready and flush, parametrised by entry width.
- Port register bank and pointer logic stay in the top.

Test Plan:
- NUM_PORTS=2, PTR_MODE=0, iw_ready=1: stream addrs 0x10, 0x20, 0x30 every cycle -> ow_mem_port alternates 0,1,0; each port register shows its addr the cycle after accept; latency 1.
- NUM_PORTS=3, PTR_MODE=1: mem bundles A=0x100, non-mem, B=0x200, C=0x300, D=0x400 -> ports 0, -, 1, 2, 0 (wrap); non-mem bundle leaves all port registers unchanged.
- Hold iw_ready=0 for 3 cycles while presenting 3 bundles -> first in O, second in S, ow_ready=0 on cycle 2, third held upstream; release -> outputs in order, no loss or duplication.
- Assert iw_flush with O and S full and iw_valid=1 -> next cycle ow_valid=0, ow_ready=1, pointer unchanged, flushing-cycle input discarded.
- Assert iw_rst_n low mid-stall (async, off clock edge) -> all outputs 0 immediately; after release first accepted mem bundle gets port 0.
- STG_MA_ALIGN_CHK_EN, wide mem access at addr 0x101 -> ow_fault=1, ow_mem_req=0, port registers and pointer unchanged; addr 0x100 -> no fault.

Source files
------------

// File: rtl/stg_ma_mp_pkg.sv
// Shared definitions for the MA stage: pointer-width helper, pointer modes and
// the bit layout of the opaque sideband payload packed upstream.
package stg_ma_mp_pkg;

    typedef enum int {
        PTR_FREE_RUN = 0,
        PTR_ON_XFER  = 1
    } ptr_mode_e;

    // Sideband payload layout (PAY_W = 96)
    localparam int PAY_PC_LSB     = 0;
    localparam int PAY_PC_W       = 24;
    localparam int PAY_INSTR_LSB  = 24;
    localparam int PAY_INSTR_W    = 24;
    localparam int PAY_OPC_LSB    = 48;
    localparam int PAY_OPC_W      = 8;
    localparam int PAY_TGT_GP_LSB = 56;
    localparam int PAY_TGT_GP_W   = 4;
    localparam int PAY_TGT_SR_LSB = 60;
    localparam int PAY_TGT_SR_W   = 2;
    localparam int PAY_TGT_AR_LSB = 62;
    localparam int PAY_TGT_AR_W   = 2;
    localparam int PAY_RES_LSB    = 64;
    localparam int PAY_RES_W      = 24;
    localparam int PAY_CR_LSB     = 88;
    localparam int PAY_CR_W       = 8;

    function automatic int ptr_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/stg_ma_skid.sv
// Two-entry output/skid register with valid/ready handshake and flush.
// The low TAG_W bits of the skid entry are exported for hazard checks upstream.
module stg_ma_skid #(
    parameter int W     = 8,
    parameter int TAG_W = 1
) (
    input  logic             iw_clk,
    input  logic             iw_rst_n,
    input  logic             iw_valid,
    input  logic [W-1:0]     iw_data,
    output logic             ow_ready,
    input  logic             iw_flush,
    output logic             ow_valid,
    output logic [W-1:0]     ow_data,
    input  logic             iw_ready,
    output logic             ow_s_valid,
    output logic [TAG_W-1:0] ow_s_tag
);

    logic         o_valid_reg;
    logic         s_valid_reg;
    logic [W-1:0] o_data_reg;
    logic [W-1:0] s_data_reg;
    logic         accept;

    assign accept = iw_valid && !s_valid_reg;

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            o_valid_reg <= 1'b0;
            s_valid_reg <= 1'b0;
            o_data_reg  <= '0;
            s_data_reg  <= '0;
        end else if (iw_flush) begin
            o_valid_reg <= 1'b0;
            s_valid_reg <= 1'b0;
        end else if (o_valid_reg && iw_ready) begin
            // Draining: the skid entry always goes first to keep FIFO order
            if (s_valid_reg) begin
                o_data_reg  <= s_data_reg;
                s_valid_reg <= 1'b0;
            end else if (accept) begin
                o_data_reg <= iw_data;
            end else begin
                o_valid_reg <= 1'b0;
            end
        end else if (accept) begin
            if (!o_valid_reg) begin
                o_valid_reg <= 1'b1;
                o_data_reg  <= iw_data;
            end else begin
                s_valid_reg <= 1'b1;
                s_data_reg  <= iw_data;
            end
        end
    end

    assign ow_ready   = !s_valid_reg;
    assign ow_valid   = o_valid_reg;
    assign ow_data    = o_data_reg;
    assign ow_s_valid = s_valid_reg;
    assign ow_s_tag   = s_data_reg[TAG_W-1:0];

endmodule

// File: rtl/stg_ma_mp.sv
// MA pipeline stage: skid-buffered bundle plus a bank of registered memory-address
// ports allocated by a rotating pointer. Optional STG_MA_ALIGN_CHK_EN adds a 48-bit alignment fault.
module stg_ma_mp
    import stg_ma_mp_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int PAY_W     = 96,
    parameter int NUM_PORTS = 2,
    parameter int PTR_MODE  = 0
) (
    input  logic                              iw_clk,
    input  logic                              iw_rst_n,
    input  logic                              iw_valid,
    output logic                              ow_ready,
    input  logic                              iw_mem_req,
    input  logic                              iw_wide,
    input  logic [ADDR_W-1:0]                 iw_addr,
    input  logic [PAY_W-1:0]                  iw_payload,
    input  logic                              iw_flush,
    output logic                              ow_valid,
    input  logic                              iw_ready,
    output logic [PAY_W-1:0]                  ow_payload,
    output logic                              ow_mem_req,
    output logic                              ow_wide,
    output logic [ptr_width(NUM_PORTS)-1:0]   ow_mem_port,
    output logic [NUM_PORTS*ADDR_W-1:0]       ow_mem_addr,
    output logic                              ow_fault
);

    localparam int PTR_W  = ptr_width(NUM_PORTS);
    localparam int TAG_W  = 1 + PTR_W;
    localparam int BASE_W = TAG_W + 1 + PAY_W;
`ifdef STG_MA_ALIGN_CHK_EN
    localparam int ENT_W  = BASE_W + 1;
`else
    localparam int ENT_W  = BASE_W;
`endif
    localparam bit ON_XFER = (PTR_MODE == int'(PTR_ON_XFER));

    logic [PTR_W-1:0] r_ptr_reg;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] port_in;
    logic             skid_ready;
    logic             o_valid;
    logic             s_valid;
    logic [TAG_W-1:0] s_tag;
    logic [ENT_W-1:0] in_ent;
    logic [ENT_W-1:0] o_ent;
    logic             fault_in;
    logic             mem_eff;
    logic             conflict;
    logic             acc;

    // Entry layout, LSB first: mem_req, port, wide, payload[, fault]
`ifdef STG_MA_ALIGN_CHK_EN
    assign fault_in = iw_mem_req && iw_wide && iw_addr[0];
    assign in_ent   = {fault_in, iw_payload, iw_wide, port_in, mem_eff};
    assign ow_fault = o_valid && o_ent[ENT_W-1];
`else
    assign fault_in = 1'b0;
    assign in_ent   = {iw_payload, iw_wide, port_in, mem_eff};
    assign ow_fault = 1'b0;
`endif

    assign mem_eff = iw_mem_req && !fault_in;
    assign port_in = mem_eff ? r_ptr_reg : '0;

    // A port still referenced by a held memory bundle must not be handed out again
    assign conflict = ON_XFER &&
                      ((o_valid && o_ent[0]  && (o_ent[1 +: PTR_W]  == r_ptr_reg)) ||
                       (s_valid && s_tag[0]  && (s_tag[1 +: PTR_W]  == r_ptr_reg)));

    assign ow_ready = skid_ready && !conflict;
    assign acc      = iw_valid && ow_ready && !iw_flush;
    assign ptr_next = (r_ptr_reg == PTR_W'(NUM_PORTS - 1)) ? '0 : r_ptr_reg + PTR_W'(1);

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_ptr_reg <= '0;
        end else if (!ON_XFER || (acc && mem_eff)) begin
            r_ptr_reg <= ptr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [ADDR_W-1:0] port_addr_reg;

            always_ff @(posedge iw_clk or negedge iw_rst_n) begin
                if (!iw_rst_n) begin
                    port_addr_reg <= '0;
                end else if (acc && mem_eff && (r_ptr_reg == PTR_W'(gi))) begin
                    port_addr_reg <= iw_addr;
                end
            end

            assign ow_mem_addr[gi*ADDR_W +: ADDR_W] = port_addr_reg;
        end
    endgenerate

    stg_ma_skid #(
        .W     (ENT_W),
        .TAG_W (TAG_W)
    ) u_skid (
        .iw_clk     (iw_clk),
        .iw_rst_n   (iw_rst_n),
        .iw_valid   (iw_valid && ow_ready),
        .iw_data    (in_ent),
        .ow_ready   (skid_ready),
        .iw_flush   (iw_flush),
        .ow_valid   (o_valid),
        .ow_data    (o_ent),
        .iw_ready   (iw_ready),
        .ow_s_valid (s_valid),
        .ow_s_tag   (s_tag)
    );

    assign ow_valid    = o_valid;
    assign ow_mem_req  = o_ent[0];
    assign ow_mem_port = o_ent[1 +: PTR_W];
    assign ow_wide     = o_ent[TAG_W];
    assign ow_payload  = o_ent[TAG_W+1 +: PAY_W];

endmodule

// File: tb/tb_stg_ma_mp.sv
// Bench for stg_ma_mp: a 2-port free-running instance and a 3-port on-transfer
// instance, checked against a queue-based model of the stage.
module tb_stg_ma_mp;

`ifdef STG_MA_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v_in, mem, wide, flush, rdy;
    logic [23:0] addr;
    logic [95:0] pay;
    int          sel;
    logic        v0, v1;

    assign v0 = v_in && (sel == 0);
    assign v1 = v_in && (sel == 1);

    logic        o0_valid, o0_ready, o0_mem, o0_wide, o0_fault;
    logic [95:0] o0_pay;
    logic [0:0]  o0_port;
    logic [47:0] o0_addr;
    logic        o1_valid, o1_ready, o1_mem, o1_wide, o1_fault;
    logic [95:0] o1_pay;
    logic [1:0]  o1_port;
    logic [71:0] o1_addr;

    stg_ma_mp #(.ADDR_W(24), .PAY_W(96), .NUM_PORTS(2), .PTR_MODE(0)) u0 (
        .iw_clk(clk), .iw_rst_n(rst_n), .iw_valid(v0), .ow_ready(o0_ready),
        .iw_mem_req(mem), .iw_wide(wide), .iw_addr(addr), .iw_payload(pay),
        .iw_flush(flush), .ow_valid(o0_valid), .iw_ready(rdy), .ow_payload(o0_pay),
        .ow_mem_req(o0_mem), .ow_wide(o0_wide), .ow_mem_port(o0_port),
        .ow_mem_addr(o0_addr), .ow_fault(o0_fault)
    );

    stg_ma_mp #(.ADDR_W(24), .PAY_W(96), .NUM_PORTS(3), .PTR_MODE(1)) u1 (
        .iw_clk(clk), .iw_rst_n(rst_n), .iw_valid(v1), .ow_ready(o1_ready),
        .iw_mem_req(mem), .iw_wide(wide), .iw_addr(addr), .iw_payload(pay),
        .iw_flush(flush), .ow_valid(o1_valid), .iw_ready(rdy), .ow_payload(o1_pay),
        .ow_mem_req(o1_mem), .ow_wide(o1_wide), .ow_mem_port(o1_port),
        .ow_mem_addr(o1_addr), .ow_fault(o1_fault)
    );

    typedef struct {
        logic [95:0] pay;
        logic        mem;
        logic        wide;
        int          port;
        logic        fault;
    } bun_t;

    bun_t        q[$];
    int          ptr0, ptr1;
    logic [23:0] pa0[2];
    logic [23:0] pa1[3];
    int          nvec, nfail;
    bit          taken;

    function automatic bit mready();
        if (q.size() >= 2) return 1'b0;
        if (sel == 1)
            foreach (q[i])
                if (q[i].mem && q[i].port == ptr1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ptr0 = 0;
        ptr1 = 0;
        foreach (pa0[k]) pa0[k] = '0;
        foreach (pa1[k]) pa1[k] = '0;
    endtask

    task automatic model_edge();
        bun_t b;
        bit   r, a;
        r       = mready();
        a       = v_in && r && !flush;
        b.pay   = pay;
        b.wide  = wide;
        b.fault = ALIGN && mem && wide && addr[0];
        b.mem   = mem && !b.fault;
        b.port  = b.mem ? ((sel == 0) ? ptr0 : ptr1) : 0;
        taken   = a || (v_in && flush);
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (a) begin
                q.push_back(b);
                if (b.mem) begin
                    if (sel == 0) pa0[b.port] = addr;
                    else          pa1[b.port] = addr;
                    if (sel == 1) ptr1 = (ptr1 + 1) % 3;
                end
            end
        end
        ptr0 = (ptr0 + 1) % 2;
    endtask

    task automatic check_all();
        logic        ov, ordy, om, ow, of;
        logic [95:0] op;
        int          oport;
        if (sel == 0) begin
            ov = o0_valid; ordy = o0_ready; om = o0_mem; ow = o0_wide; of = o0_fault;
            op = o0_pay; oport = int'(o0_port);
        end else begin
            ov = o1_valid; ordy = o1_ready; om = o1_mem; ow = o1_wide; of = o1_fault;
            op = o1_pay; oport = int'(o1_port);
        end
        chk("valid", 128'(ov), 128'(q.size() > 0));
        chk("ready", 128'(ordy), 128'(mready()));
        chk("fault", 128'(of), 128'((q.size() > 0) ? q[0].fault : 1'b0));
        if (q.size() > 0) begin
            chk("payload", 128'(op), 128'(q[0].pay));
            chk("mem_req", 128'(om), 128'(q[0].mem));
            chk("wide", 128'(ow), 128'(q[0].wide));
            chk("port", 128'(oport), 128'(q[0].port));
        end
        for (int k = 0; k < 2; k++) chk("addr_u0", 128'(o0_addr[k*24 +: 24]), 128'(pa0[k]));
        for (int k = 0; k < 3; k++) chk("addr_u1", 128'(o1_addr[k*24 +: 24]), 128'(pa1[k]));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_all();
    endtask

    task automatic put(input bit v, input bit m, input bit w, input logic [23:0] a,
                       input bit fl, input bit r);
        v_in = v; mem = m; wide = w; addr = a; flush = fl; rdy = r;
        pay = {$urandom(), $urandom(), $urandom()};
    endtask

    task automatic hold_until_taken();
        for (int i = 0; i < 8; i++) begin
            step();
            if (taken) begin
                v_in = 1'b0;
                return;
            end
        end
        nvec++;
        nfail++;
        $error("FAIL handshake_timeout observed=not_accepted expected=accepted");
        v_in = 1'b0;
    endtask

    task automatic reset_outputs_check();
        chk("rst_valid0", 128'(o0_valid), 128'(0));
        chk("rst_ready0", 128'(o0_ready), 128'(1));
        chk("rst_pay0", 128'(o0_pay), 128'(0));
        chk("rst_mem0", 128'({o0_mem, o0_wide, o0_port, o0_fault}), 128'(0));
        chk("rst_addr0", 128'(o0_addr), 128'(0));
        chk("rst_valid1", 128'(o1_valid), 128'(0));
        chk("rst_ready1", 128'(o1_ready), 128'(1));
        chk("rst_pay1", 128'(o1_pay), 128'(0));
        chk("rst_mem1", 128'({o1_mem, o1_wide, o1_port, o1_fault}), 128'(0));
        chk("rst_addr1", 128'(o1_addr), 128'(0));
    endtask

    task automatic idle(input int n);
        put(0, 0, 0, '0, 0, 1);
        repeat (n) step();
    endtask

    initial begin
        bit held;
        nvec = 0;
        nfail = 0;
        sel = 0;
        rst_n = 1'b0;
        put(0, 0, 0, '0, 0, 1);
        model_reset();
        #3;
        reset_outputs_check();
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running 2-port stream
        put(1, 1, 0, 24'h10, 0, 1); step();
        put(1, 1, 0, 24'h20, 0, 1); step();
        put(1, 1, 0, 24'h30, 0, 1); step();
        idle(2);

        // On-transfer 3-port allocation with wrap and a non-memory bundle
        sel = 1;
        put(1, 1, 0, 24'h100, 0, 1); step();
        put(1, 0, 0, 24'hABC, 0, 1); step();
        put(1, 1, 0, 24'h200, 0, 1); step();
        put(1, 1, 0, 24'h300, 0, 1); step();
        put(1, 1, 0, 24'h400, 0, 1); step();
        chk("tp_port0", 128'(o1_addr[23:0]),  128'(24'h400));
        chk("tp_port1", 128'(o1_addr[47:24]), 128'(24'h200));
        chk("tp_port2", 128'(o1_addr[71:48]), 128'(24'h300));
        idle(2);

        // Downstream stall with three bundles
        put(1, 1, 0, 24'h500, 0, 0); step();
        put(1, 0, 0, 24'h000, 0, 0); step();
        put(1, 1, 0, 24'h600, 0, 0); step();
        chk("stall_ready", 128'(o1_ready), 128'(0));
        rdy = 1'b1;
        hold_until_taken();
        idle(3);

        // Flush with both entries full and a bundle on the input
        put(1, 1, 0, 24'h700, 0, 0); step();
        put(1, 1, 0, 24'h710, 0, 0); step();
        put(1, 1, 0, 24'h720, 1, 0); step();
        chk("flush_valid", 128'(o1_valid), 128'(0));
        idle(2);

        // Asynchronous reset in the middle of a stall
        put(1, 1, 0, 24'h800, 0, 0); step();
        put(1, 1, 0, 24'h810, 0, 0); step();
        #3;
        rst_n = 1'b0;
        v_in = 1'b0;
        model_reset();
        #1;
        reset_outputs_check();
        @(negedge clk);
        rst_n = 1'b1;
        put(1, 1, 0, 24'h900, 0, 1); step();
        chk("post_reset_port", 128'(o1_port), 128'(0));
        idle(2);

        // Wide access alignment
        put(1, 1, 1, 24'h101, 0, 1); step();
        put(1, 1, 1, 24'h100, 0, 1); step();
        idle(2);

        // Randomized traffic on each instance
        for (int s = 0; s < 2; s++) begin
            put(0, 0, 0, '0, 1, 1); step();
            sel = s;
            held = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (!held) begin
                    put(($urandom % 4) != 0, ($urandom % 3) != 0, $urandom % 2,
                        24'($urandom), 0, 1);
                end
                flush = (($urandom % 25) == 0);
                rdy   = (($urandom % 3) != 0);
                step();
                held = v_in && !taken;
            end
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
